multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port CLK, input, 1, sole clock; all state updates on posedge CLK.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-003 SHALL have port opcode, input, 11, instruction[31:21] taken from the instruction register.
REQ-004 SHALL have port zero, input, 1, ALU zero flag.
REQ-005 SHALL have port mem_ready, input, 1, memory completes the current access this cycle.
REQ-006 SHALL have port memread / memwrite, output, 1 each, memory access strobes.
REQ-007 SHALL have port iord, output, 1, memory address select: 0 = PC, 1 = ALU result register.
REQ-008 SHALL have port irwrite / pcwrite / regwrite, output, 1 each, register load enables.
REQ-009 SHALL have port reg2loc / mem2reg / alusrca, output, 1 each, datapath mux selects.
REQ-010 SHALL have port alusrcb, output, 2, ALU B select: 00 = regB, 01 = constant 4, 10 = extended immediate.
REQ-011 SHALL have port pcsrc, output, 1, PC source: 0 = ALU (PC+4), 1 = branch target.
REQ-012 SHALL have port aluop, output, 4, ALU control: AND 0000, ORR 0001, ADD 0010, SUB 0110, PASSB 0111.
REQ-013 SHALL have port signop, output, 3, extender control: D 000, I 001, B 010, CBZ 011, MOVZ 100.
REQ-014 SHALL have port state, output, 3, current FSM state encoding.
REQ-015 SHALL have port illegal, output, 1, one-cycle pulse on an undecodable opcode.

Function
REQ-016 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 SHALL go to FETCH on the next edge.
REQ-017 SHALL hold outputs as a function of state plus the latched opcode class; all strobes and enables SHALL be 0 outside the states named below.
REQ-018 FETCH: SHALL assert memread=1, iord=0, alusrca=0, alusrcb=01, aluop=ADD and pcsrc=0; SHALL stay in FETCH while mem_ready=0.
REQ-019 FETCH with mem_ready=1: SHALL assert irwrite=1 and pcwrite=1 for exactly that cycle, then go to DECODE.
REQ-020 DECODE: SHALL latch the opcode class (R: ADD/SUB/AND/ORR, LDUR, STUR, CBZ, B, MOVZ) and SHALL set reg2loc=1 only for STUR/CBZ; always proceeds to EXEC next cycle.
REQ-021 DECODE with no class matching: SHALL pulse illegal=1 and go to FETCH; no pcwrite/regwrite/memwrite asserted.
REQ-022 Opcode matches: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, LDUR 11111000010, STUR 11111000000, CBZ 10110100xxx, B 000101xxxxx, MOVZ 110100101xx (x = don't care).
REQ-023 EXEC R-type: alusrca=1, alusrcb=00, aluop per opcode -> WB.
REQ-024 EXEC LDUR/STUR: alusrca=1, alusrcb=10, signop=000, aluop=ADD -> MEM.
REQ-025 EXEC MOVZ: alusrcb=10, signop=100, aluop=PASSB -> WB.
REQ-026 EXEC CBZ: alusrcb=00, aluop=PASSB, signop=011; pcwrite=zero, pcsrc=1 -> FETCH.
REQ-027 EXEC B: signop=010, pcwrite=1, pcsrc=1 -> FETCH.
REQ-028 MEM LDUR: memread=1, iord=1; hold until mem_ready=1, then -> WB.
REQ-029 MEM STUR: memwrite=1, iord=1; hold until mem_ready=1, then -> FETCH; memwrite SHALL remain asserted every waiting cycle.
REQ-030 WB: regwrite=1 for one cycle; mem2reg=1 only for LDUR; -> FETCH.
REQ-031 Latency with mem_ready tied to 1: R/MOVZ 4 cycles, LDUR 5, STUR 4, CBZ/B 3.
REQ-032 An opcode input change outside DECODE SHALL NOT affect the latched class.

Reset
REQ-033 reset=1 at posedge SHALL force state=FETCH and clear latched class and illegal, overriding any pending transition, including mid-MEM.
REQ-034 While in FETCH after reset, outputs SHALL equal REQ-018 values; pcwrite=irwrite=0 until mem_ready=1 is sampled with reset=0.

Verification
REQ-035 ADD opcode 10001011000, mem_ready=1 -> states 0,1,2,4,0; regwrite=1 only in WB, aluop=0010 in EXEC.
REQ-036 LDUR, mem_ready low 3 cycles in MEM -> state holds 3 for 4 cycles, memread=iord=1 throughout, then WB with mem2reg=1.
REQ-037 CBZ with zero=0 then zero=1 -> pcwrite=0 then pcwrite=1, pcsrc=1, in EXEC; back to FETCH.
REQ-038 Opcode 00000000000 -> illegal=1 for one cycle in DECODE, next state FETCH, no regwrite/memwrite.
REQ-039 STUR with reset asserted in MEM -> next state FETCH, memwrite=0 from that edge.
REQ-040 FETCH with mem_ready=0 for 5 cycles -> irwrite/pcwrite stay 0, state holds 0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle LEGv8-style control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with
// datapath controls decoded from the current state and the instruction class latched in DECODE.
module multicycle_control (
  input  logic       CLK,
  input  logic       reset,
  input  logic [10:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       memread,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic       reg2loc,
  output logic       mem2reg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       pcsrc,
  output logic [3:0] aluop,
  output logic [2:0] signop,
  output logic [2:0] state,
  output logic       illegal
);

  localparam int unsigned STATE_W  = 3;
  localparam int unsigned CLASS_W  = 4;
  localparam int unsigned ALUOP_W  = 4;
  localparam int unsigned SIGNOP_W = 3;
  localparam int unsigned SRCB_W   = 2;

  localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(4'b0000);
  localparam logic [ALUOP_W-1:0] ALU_ORR   = ALUOP_W'(4'b0001);
  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(4'b0010);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(4'b0110);
  localparam logic [ALUOP_W-1:0] ALU_PASSB = ALUOP_W'(4'b0111);

  localparam logic [SIGNOP_W-1:0] EXT_D    = SIGNOP_W'(3'b000);
  localparam logic [SIGNOP_W-1:0] EXT_B    = SIGNOP_W'(3'b010);
  localparam logic [SIGNOP_W-1:0] EXT_CBZ  = SIGNOP_W'(3'b011);
  localparam logic [SIGNOP_W-1:0] EXT_MOVZ = SIGNOP_W'(3'b100);

  localparam logic [SRCB_W-1:0] SRCB_REG  = SRCB_W'(2'b00);
  localparam logic [SRCB_W-1:0] SRCB_FOUR = SRCB_W'(2'b01);
  localparam logic [SRCB_W-1:0] SRCB_IMM  = SRCB_W'(2'b10);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [CLASS_W-1:0] {
    C_NONE = 4'd0,
    C_ADD  = 4'd1,
    C_SUB  = 4'd2,
    C_AND  = 4'd3,
    C_ORR  = 4'd4,
    C_LDUR = 4'd5,
    C_STUR = 4'd6,
    C_CBZ  = 4'd7,
    C_B    = 4'd8,
    C_MOVZ = 4'd9
  } class_t;

  state_t r_state;
  state_t w_next;
  class_t r_class;
  class_t w_dec_class;

  // Instruction class of the opcode currently presented by the instruction register
  always_comb begin
    w_dec_class = C_NONE;
    casez (opcode)
      11'b10001011000: w_dec_class = C_ADD;
      11'b11001011000: w_dec_class = C_SUB;
      11'b10001010000: w_dec_class = C_AND;
      11'b10101010000: w_dec_class = C_ORR;
      11'b11111000010: w_dec_class = C_LDUR;
      11'b11111000000: w_dec_class = C_STUR;
      11'b10110100???: w_dec_class = C_CBZ;
      11'b000101?????: w_dec_class = C_B;
      11'b110100101??: w_dec_class = C_MOVZ;
      default:         w_dec_class = C_NONE;
    endcase
  end

  // Class is captured only on the DECODE edge so later opcode changes are ignored
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_class <= C_NONE;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_class <= w_dec_class;
      end
    end
  end

  always_comb begin
    w_next   = r_state;
    memread  = 1'b0;
    memwrite = 1'b0;
    iord     = 1'b0;
    irwrite  = 1'b0;
    pcwrite  = 1'b0;
    regwrite = 1'b0;
    reg2loc  = 1'b0;
    mem2reg  = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = SRCB_REG;
    pcsrc    = 1'b0;
    aluop    = ALU_AND;
    signop   = EXT_D;
    illegal  = 1'b0;

    case (r_state)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = SRCB_FOUR;
        aluop   = ALU_ADD;
        // A mem_ready seen while reset is held must not load IR or PC
        if (mem_ready && !reset) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          w_next  = S_DECODE;
        end
      end

      S_DECODE: begin
        reg2loc = (w_dec_class == C_STUR) || (w_dec_class == C_CBZ);
        if (w_dec_class == C_NONE) begin
          illegal = !reset;
          w_next  = S_FETCH;
        end else begin
          w_next  = S_EXEC;
        end
      end

      S_EXEC: begin
        w_next = S_FETCH;
        case (r_class)
          C_ADD, C_SUB, C_AND, C_ORR: begin
            alusrca = 1'b1;
            alusrcb = SRCB_REG;
            case (r_class)
              C_SUB:   aluop = ALU_SUB;
              C_AND:   aluop = ALU_AND;
              C_ORR:   aluop = ALU_ORR;
              default: aluop = ALU_ADD;
            endcase
            w_next = S_WB;
          end
          C_LDUR, C_STUR: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
            signop  = EXT_D;
            aluop   = ALU_ADD;
            w_next  = S_MEM;
          end
          C_MOVZ: begin
            alusrcb = SRCB_IMM;
            signop  = EXT_MOVZ;
            aluop   = ALU_PASSB;
            w_next  = S_WB;
          end
          C_CBZ: begin
            alusrcb = SRCB_REG;
            aluop   = ALU_PASSB;
            signop  = EXT_CBZ;
            pcwrite = zero;
            pcsrc   = 1'b1;
          end
          C_B: begin
            signop  = EXT_B;
            pcwrite = 1'b1;
            pcsrc   = 1'b1;
          end
          default: w_next = S_FETCH;
        endcase
      end

      S_MEM: begin
        w_next = S_FETCH;
        if (r_class == C_LDUR) begin
          memread = 1'b1;
          iord    = 1'b1;
          w_next  = mem_ready ? S_WB : S_MEM;
        end else if (r_class == C_STUR) begin
          memwrite = 1'b1;
          iord     = 1'b1;
          w_next   = mem_ready ? S_FETCH : S_MEM;
        end
      end

      S_WB: begin
        regwrite = 1'b1;
        mem2reg  = (r_class == C_LDUR);
        w_next   = S_FETCH;
      end

      default: w_next = S_FETCH;
    endcase
  end

  assign state = r_state;

endmodule
